// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: buffers single-cycle write strobes and drains one byte
// per serial frame using the tx_start / tx_busy handshake, abandoning a frame if busy never rises.
module uart_tx_fifo #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int BUSY_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          ovf_sticky,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    input  logic          tx_busy,
    output logic          tx_err
);

    localparam int WW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          ovf_sticky_q, ovf_sticky_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          tx_err_c;

    logic          pop;
    logic          wr_accept;
    logic          wr_drop;

    // A pop frees a slot in the same cycle, so a write at full is still accepted when paired with a pop.
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign wr_accept = wr_en && ((count_q < (AW+1)'(DEPTH)) || pop);
    assign wr_drop   = wr_en && !wr_accept;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        tx_data_d    = tx_data_q;
        overflow_d   = wr_drop;
        ovf_sticky_d = ovf_sticky_q | wr_drop;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            tx_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + AW'(1);
        end

        if (wr_accept && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !wr_accept) begin
            count_d = count_q - (AW+1)'(1);
        end

        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    // A busy timeout drops the byte without retry; the next byte is popped on return to IDLE.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        tx_err_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = START;
                end
            end
            START: begin
                state_d    = WAIT_HI;
                wait_cnt_d = '0;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (wait_cnt_q == WW'(BUSY_WAIT - 1)) begin
                    tx_err_c = 1'b1;
                    state_d  = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            overflow_q   <= 1'b0;
            ovf_sticky_q <= 1'b0;
            tx_data_q    <= 8'h00;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            overflow_q   <= overflow_d;
            ovf_sticky_q <= ovf_sticky_d;
            tx_data_q    <= tx_data_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // Storage carries no reset; at full wr_ptr equals rd_ptr, and the pop reads the old byte before it is overwritten.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full       = full_q;
    assign empty      = empty_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign ovf_sticky = ovf_sticky_q;
    assign tx_start   = (state_q == START);
    assign tx_data    = tx_data_q;
    assign tx_err     = tx_err_c;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a queue-based model predicts the bytes, start/err timing and flags,
// and a uart_tx stand-in drives tx_busy for a chosen frame length after each start.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          ovf_sticky;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic          tx_err;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .BUSY_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .ovf_sticky (ovf_sticky),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] cnt;
        logic       ovf;
        logic       sticky;
        logic [7:0] txd;
    } snap_t;

    typedef struct packed {
        int         cyc;
        logic [7:0] data;
    } txexp_t;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          started = 0;

    snap_t       exp_snap [int];
    txexp_t      exp_tx [$];
    int          exp_err [$];
    logic [7:0]  model_q [$];
    int          free_at = 0;
    int          busy_from = 0;
    int          busy_until = -1;
    logic        sticky_m = 1'b0;
    logic [7:0]  last_txd = 8'h00;
    int          frame_len = 10;
    bit          rand_frames = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock of stimulus; the model decides pops from the handshake timeline it has scheduled itself.
    task automatic applyStimulus(input logic we, input logic [7:0] d);
        int    k;
        int    n;
        bit    pop_now;
        bit    drop;
        snap_t s;
        k       = cyc;
        tx_busy = (k >= busy_from) && (k <= busy_until);
        pop_now = (k >= free_at) && (model_q.size() != 0);
        drop    = we && (model_q.size() == DEPTH) && !pop_now;
        if (pop_now) begin
            txexp_t e;
            last_txd = model_q.pop_front();
            e.cyc    = k + 1;
            e.data   = last_txd;
            exp_tx.push_back(e);
            n = rand_frames ? int'($urandom_range(0, 12)) : frame_len;
            if (n == 0) begin
                exp_err.push_back(k + 5);
                busy_from  = 0;
                busy_until = -1;
                free_at    = k + 6;
            end else begin
                busy_from  = k + 2;
                busy_until = k + 1 + n;
                free_at    = k + n + 3;
            end
        end
        if (we && !drop) model_q.push_back(d);
        sticky_m     = sticky_m | drop;
        s.cnt        = 5'(model_q.size());
        s.ovf        = drop;
        s.sticky     = sticky_m;
        s.txd        = last_txd;
        exp_snap[k + 1] = s;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        snap_t s;
        model_q.delete();
        exp_tx.delete();
        exp_err.delete();
        busy_from  = 0;
        busy_until = -1;
        sticky_m   = 1'b0;
        last_txd   = 8'h00;
        s.cnt      = '0;
        s.ovf      = 1'b0;
        s.sticky   = 1'b0;
        s.txd      = 8'h00;
        exp_snap[cyc] = s;
        free_at    = cyc;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00);
    endtask

    task automatic drain(input int limit);
        int i;
        i = 0;
        while ((model_q.size() != 0 || cyc < free_at) && i < limit) begin
            applyStimulus(1'b0, 8'h00);
            i++;
        end
        idleCycles(3);
        checkOutput("drained_count", 32'(count), 0);
    endtask

    // Monitor: per-cycle flags against the model snapshot, starts and errors against their queues.
    always @(negedge clk) begin : monitor
        snap_t  s;
        txexp_t e;
        if (started && !rst) begin
            if (!exp_snap.exists(cyc)) begin
                checkOutput("snap_exists", 32'(exp_snap.exists(cyc)), 1);
            end else begin
                s = exp_snap[cyc];
                checkOutput("count", 32'(count), 32'(s.cnt));
                checkOutput("full", 32'(full), 32'(s.cnt == 5'd16));
                checkOutput("empty", 32'(empty), 32'(s.cnt == 5'd0));
                checkOutput("overflow", 32'(overflow), 32'(s.ovf));
                checkOutput("ovf_sticky", 32'(ovf_sticky), 32'(s.sticky));
                checkOutput("tx_data_hold", 32'(tx_data), 32'(s.txd));
            end
            if (tx_start) begin
                if (exp_tx.size() == 0) begin
                    checkOutput("unexpected_tx_start", 32'(tx_start), 0);
                end else begin
                    e = exp_tx.pop_front();
                    checkOutput("tx_start_cycle", cyc, e.cyc);
                    checkOutput("tx_data_at_start", 32'(tx_data), 32'(e.data));
                end
            end else if (exp_tx.size() != 0 && exp_tx[0].cyc <= cyc) begin
                checkOutput("missing_tx_start", 32'(tx_start), 1);
                void'(exp_tx.pop_front());
            end
            if (tx_err) begin
                if (exp_err.size() == 0) begin
                    checkOutput("unexpected_tx_err", 32'(tx_err), 0);
                end else begin
                    checkOutput("tx_err_cycle", cyc, exp_err.pop_front());
                end
            end else if (exp_err.size() != 0 && exp_err[0] <= cyc) begin
                checkOutput("missing_tx_err", 32'(tx_err), 1);
                void'(exp_err.pop_front());
            end
        end
    end

    initial begin
        bit found;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_empty", 32'(empty), 1);
        checkOutput("reset_tx_data", 32'(tx_data), 0);
        rst = 1'b0;
        modelReset();
        started = 1;

        $display("[TB] single byte");
        frame_len = 10;
        applyStimulus(1'b1, 8'hA5);
        idleCycles(20);

        $display("[TB] burst fill and overflow");
        frame_len = 100;
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(i));
        applyStimulus(1'b1, 8'hEE);
        applyStimulus(1'b1, 8'hEE);
        drain(3000);

        $display("[TB] write plus pop at full");
        frame_len = 20;
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 8'(8'h10 + i));
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (cyc >= free_at && model_q.size() == DEPTH) begin
                applyStimulus(1'b1, 8'h55);
                found = 1;
            end else begin
                applyStimulus(1'b0, 8'h00);
            end
        end
        checkOutput("wp_full_found", 32'(found), 1);
        drain(1000);

        $display("[TB] busy timeout");
        frame_len = 0;
        applyStimulus(1'b1, 8'h3C);
        applyStimulus(1'b1, 8'hC3);
        applyStimulus(1'b1, 8'h5A);
        drain(100);

        $display("[TB] random traffic");
        rand_frames = 1;
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 60), 8'($urandom));
        end
        drain(1000);
        rand_frames = 0;

        $display("[TB] reset mid-frame");
        frame_len = 30;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'hB0 + i));
        for (int i = 0; i < 50 && !(busy_until >= 0 && cyc == busy_from + 3); i++) begin
            applyStimulus(1'b0, 8'h00);
        end
        rst     = 1'b1;
        wr_en   = 1'b0;
        tx_busy = 1'b0;
        #1;
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_overflow", 32'(overflow), 0);
        checkOutput("rst_ovf_sticky", 32'(ovf_sticky), 0);
        checkOutput("rst_tx_start", 32'(tx_start), 0);
        checkOutput("rst_tx_data", 32'(tx_data), 0);
        checkOutput("rst_tx_err", 32'(tx_err), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        idleCycles(30);
        applyStimulus(1'b1, 8'h7E);
        drain(100);

        checkOutput("pending_tx", exp_tx.size(), 0);
        checkOutput("pending_err", exp_err.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
